// File: rtl/sfx_sequencer_pkg.sv
// Shared types for the sound-effect sequencer: note ROM entry layout,
// sequence start addresses, trigger priorities and FSM state encoding.
package sfx_sequencer_pkg;

    localparam int ROM_AW     = 4;
    localparam int NOTE_HP_W  = 15;
    localparam int NOTE_DUR_W = 8;

    typedef struct packed {
        logic [NOTE_HP_W-1:0]  hp;
        logic [NOTE_DUR_W-1:0] dur;
        logic                  last;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } sfx_state_e;

    typedef enum logic [1:0] {
        PRIO_BONUS = 2'd0,
        PRIO_GOAL  = 2'd1,
        PRIO_CRASH = 2'd2
    } sfx_prio_e;

    localparam logic [ROM_AW-1:0] SEQ_CRASH = 4'd0;
    localparam logic [ROM_AW-1:0] SEQ_BONUS = 4'd4;
    localparam logic [ROM_AW-1:0] SEQ_GOAL  = 4'd8;

    function automatic logic [ROM_AW-1:0] seq_start(input sfx_prio_e p);
        case (p)
            PRIO_CRASH: return SEQ_CRASH;
            PRIO_GOAL:  return SEQ_GOAL;
            default:    return SEQ_BONUS;
        endcase
    endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Game-logic side <-> sequencer bundle: one-cycle triggers and mute in,
// tone-stage drive and status out. Triggers are plain pulses (no handshake).
interface sfx_sequencer_if
    import sfx_sequencer_pkg::*;
#(
    parameter int HP_W = 15
);
    logic            trig_crash;
    logic            trig_goal;
    logic            trig_bonus;
    logic            mute;
    logic [HP_W-1:0] tone_half_period;
    logic            tone_en;
    logic            busy;
    sfx_state_e      dbg_state;

    modport master (
        output trig_crash, trig_goal, trig_bonus, mute,
        input  tone_half_period, tone_en, busy, dbg_state
    );

    modport slave (
        input  trig_crash, trig_goal, trig_bonus, mute,
        output tone_half_period, tone_en, busy, dbg_state
    );
endinterface

// File: rtl/sfx_note_rom.sv
// 16-entry note table with a registered read port (one cycle latency).
module sfx_note_rom
    import sfx_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] i_addr,
    output note_t             o_note
);
    note_t w_note;
    note_t r_note;

    // Unused slots decode as a terminating rest so a stray address ends the sequence.
    always_comb begin
        w_note = '{hp: '0, dur: '0, last: 1'b1};
        case (i_addr)
            4'd0:    w_note = '{hp: 15'd14204, dur: 8'd5,  last: 1'b0};
            4'd1:    w_note = '{hp: 15'd18960, dur: 8'd5,  last: 1'b0};
            4'd2:    w_note = '{hp: 15'd28408, dur: 8'd20, last: 1'b1};
            4'd4:    w_note = '{hp: 15'd28408, dur: 8'd3,  last: 1'b0};
            4'd5:    w_note = '{hp: 15'd21282, dur: 8'd3,  last: 1'b1};
            4'd8:    w_note = '{hp: 15'd28408, dur: 8'd10, last: 1'b0};
            4'd9:    w_note = '{hp: 15'd0,     dur: 8'd5,  last: 1'b0};
            4'd10:   w_note = '{hp: 15'd28408, dur: 8'd10, last: 1'b0};
            4'd11:   w_note = '{hp: 15'd14204, dur: 8'd30, last: 1'b1};
            default: w_note = '{hp: '0, dur: '0, last: 1'b1};
        endcase
    end

    always_ff @(posedge clk) begin
        r_note <= w_note;
    end

    assign o_note = r_note;
endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays ROM note sequences on game triggers with
// priority preemption, tick-based note durations and silent gaps between notes.
module sfx_sequencer
    import sfx_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int GAP_CYCLES = 50000,
    parameter int HP_W       = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    sfx_sequencer_if.slave   bus
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    sfx_state_e            r_state;
    sfx_prio_e             r_prio;
    logic [ROM_AW-1:0]     r_addr;
    logic                  r_wait;
    logic [PRE_W-1:0]      r_pre;
    logic [NOTE_DUR_W-1:0] r_dur;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_last;
    logic [HP_W-1:0]       r_hp;
    logic                  r_tone_en;
    logic                  r_busy;

    note_t     w_note;
    sfx_prio_e w_prio;
    logic      w_any;
    logic      w_start;

    sfx_note_rom u_rom (
        .clk    (clk),
        .i_addr (r_addr),
        .o_note (w_note)
    );

    always_comb begin
        w_any  = bus.trig_crash | bus.trig_goal | bus.trig_bonus;
        w_prio = PRIO_BONUS;
        if (bus.trig_crash)     w_prio = PRIO_CRASH;
        else if (bus.trig_goal) w_prio = PRIO_GOAL;
        w_start = w_any && ((r_state == ST_IDLE) || (w_prio > r_prio));
    end

    // r_wait covers the ROM read latency after a fresh start; coming from GAP
    // the address was advanced early enough that the data is already valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_prio    <= PRIO_BONUS;
            r_addr    <= '0;
            r_wait    <= 1'b0;
            r_pre     <= '0;
            r_dur     <= '0;
            r_gap     <= '0;
            r_last    <= 1'b0;
            r_hp      <= '0;
            r_tone_en <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_start) begin
            r_state   <= ST_LOAD;
            r_prio    <= w_prio;
            r_addr    <= seq_start(w_prio);
            r_wait    <= 1'b1;
            r_busy    <= 1'b1;
            r_tone_en <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (r_wait) begin
                        r_wait <= 1'b0;
                    end else begin
                        r_hp      <= HP_W'(w_note.hp);
                        r_dur     <= (w_note.dur == '0) ? NOTE_DUR_W'(1) : w_note.dur;
                        r_last    <= w_note.last;
                        r_pre     <= '0;
                        r_tone_en <= (w_note.hp != '0) & ~bus.mute;
                        r_state   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    r_tone_en <= (r_hp != '0) & ~bus.mute;
                    if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                        r_dur <= r_dur - NOTE_DUR_W'(1);
                        if (r_dur == NOTE_DUR_W'(1)) begin
                            r_tone_en <= 1'b0;
                            if (r_last) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_prio  <= PRIO_BONUS;
                            end else begin
                                r_addr  <= r_addr + ROM_AW'(1);
                                r_gap   <= '0;
                                r_state <= ST_GAP;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + PRE_W'(1);
                    end
                end
                ST_GAP: begin
                    r_tone_en <= 1'b0;
                    if (r_gap == GAP_LAST) r_state <= ST_LOAD;
                    else                   r_gap   <= r_gap + GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.tone_half_period = r_hp;
    assign bus.tone_en          = r_tone_en;
    assign bus.busy             = r_busy;
    assign bus.dbg_state        = r_state;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: each trigger expands into a per-cycle expected
// timeline (busy, sounding, half-period) that is popped one entry per clock.
module tb_sfx_sequencer;
    import sfx_sequencer_pkg::*;

    localparam int TD  = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n;

    sfx_sequencer_if #(.HP_W(15)) bus ();

    sfx_sequencer #(
        .TICK_DIV   (TD),
        .GAP_CYCLES (GAP),
        .HP_W       (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int busy_seen = 0;

    // Expected timeline, one entry per clock: {busy, sounding, hp[14:0]}
    logic [16:0] exp_q[$];
    logic [14:0] m_hp;
    logic        m_busy;
    int          m_prio;
    logic        exp_busy, exp_en;
    logic [14:0] exp_hp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // {hp, dur, last} for each sequence, transcribed from the sound design table
    function automatic logic [23:0] rom_entry(input logic [3:0] a);
        case (a)
            4'd0:    return {15'd14204, 8'd5,  1'b0};
            4'd1:    return {15'd18960, 8'd5,  1'b0};
            4'd2:    return {15'd28408, 8'd20, 1'b1};
            4'd4:    return {15'd28408, 8'd3,  1'b0};
            4'd5:    return {15'd21282, 8'd3,  1'b1};
            4'd8:    return {15'd28408, 8'd10, 1'b0};
            4'd9:    return {15'd0,     8'd5,  1'b0};
            4'd10:   return {15'd28408, 8'd10, 1'b0};
            4'd11:   return {15'd14204, 8'd30, 1'b1};
            default: return {15'd0,     8'd0,  1'b1};
        endcase
    endfunction

    function automatic void start_seq(input int p);
        logic [3:0]  a;
        logic [23:0] e;
        logic [14:0] hp;
        int          d;
        logic        done;
        exp_q.delete();
        a = (p == 2) ? 4'd0 : (p == 1) ? 4'd8 : 4'd4;
        for (int k = 0; k < 2; k++) exp_q.push_back({1'b1, 1'b0, m_hp});
        done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (!done) begin
                e  = rom_entry(a);
                hp = e[23:9];
                d  = (e[8:1] == 8'd0) ? 1 : int'(e[8:1]);
                for (int k = 0; k < d * TD; k++) exp_q.push_back({1'b1, hp != 15'd0, hp});
                if (e[0]) done = 1'b1;
                else begin
                    for (int k = 0; k < GAP + 1; k++) exp_q.push_back({1'b1, 1'b0, hp});
                    a = a + 4'd1;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_hp   = '0;
        m_busy = 1'b0;
        m_prio = 0;
    endfunction

    // Expected outputs after the coming rising edge, given the inputs sampled there
    function automatic void model_edge(input logic c, input logic g, input logic b, input logic m);
        logic [16:0] e;
        int p;
        if (!rst_n) begin
            model_reset();
            exp_busy = 1'b0; exp_en = 1'b0; exp_hp = '0;
            return;
        end
        p = c ? 2 : g ? 1 : 0;
        if ((c | g | b) && (!m_busy || p > m_prio)) begin
            m_prio = p;
            start_seq(p);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = {1'b0, 1'b0, m_hp};
        m_busy   = e[16];
        m_hp     = e[14:0];
        exp_busy = e[16];
        exp_en   = e[15] & ~m;
        exp_hp   = e[14:0];
    endfunction

    task automatic step(input logic c, input logic g, input logic b, input logic m);
        bus.trig_crash = c;
        bus.trig_goal  = g;
        bus.trig_bonus = b;
        bus.mute       = m;
        model_edge(c, g, b, m);
        @(posedge clk);
        @(negedge clk);
        check("tone_en", 32'(bus.tone_en), 32'(exp_en));
        check("tone_hp", 32'(bus.tone_half_period), 32'(exp_hp));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        if (bus.busy) busy_seen++;
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, m);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.trig_crash = 1'b0;
        bus.trig_goal  = 1'b0;
        bus.trig_bonus = 1'b0;
        bus.mute       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tone_en", 32'(bus.tone_en), 32'd0);
        check("rst_hp", 32'(bus.tone_half_period), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        idle(3, 1'b0);

        // Bonus alone: two 12-cycle notes separated by gap + load
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(40, 1'b0);

        // Goal with rest note: busy must last exactly 231 cycles
        busy_seen = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(260, 1'b0);
        check("goal_busy_len", 32'(busy_seen), 32'd231);

        // Goal preempts bonus mid-note; later bonus is ignored
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(8, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(250, 1'b0);

        // Simultaneous crash + goal: crash wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("crash_first_hp", 32'(bus.tone_half_period), 32'd14204);
        idle(140, 1'b0);

        // Mute toggled through a goal sequence; timing must not move
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 250; i++) step(1'b0, 1'b0, 1'b0, logic'((i % 13) < 5));

        // Randomized triggers and mute
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 99) == 0),
                 logic'($urandom_range(0, 79) == 0), logic'($urandom_range(0, 9) < 2));
        end
        idle(240, 1'b0);

        // Asynchronous reset in the middle of a crash note
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_tone_en", 32'(bus.tone_en), 32'd0);
        check("arst_hp", 32'(bus.tone_half_period), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
